mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Memory access controller sitting directly upstream of the 256×32 `ram` block. It accepts read requests from the instruction-fetch port and read/write requests from the data (load/store) port, arbitrates between them, and drives the RAM's single `addr`/`wr`/`wdata`/`rd` port. It absorbs the RAM's one-cycle registered read latency and the RAM's high-impedance idle `rdata`, so the core always sees stable, registered data with a single-cycle ack.

## Interface
- `ADDR_W`, 9, address width; matches RAM `addr`.
- `DATA_W`, 32, data width; matches RAM `wdata`/`rdata`.

Ports:
- `clock` in 1: single clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `if_req` in 1: fetch read request; held until `if_ack`.
- `if_addr` in ADDR_W: fetch address.
- `if_ack` out 1: one-cycle pulse; `if_rdata` valid in the same cycle.
- `if_rdata` out DATA_W: registered fetch data.
- `d_req` in 1: data request; held until `d_ack`.
- `d_we` in 1: 1 = write, 0 = read.
- `d_addr` in ADDR_W: data address.
- `d_wdata` in DATA_W: write data.
- `d_ack` out 1: one-cycle completion pulse.
- `d_rdata` out DATA_W: registered load data.
- `ram_addr` out ADDR_W: to RAM `addr`.
- `ram_wr` out 1: to RAM `wr`.
- `ram_wdata` out DATA_W: to RAM `wdata`.
- `ram_rd` out 1: to RAM `rd`.
- `ram_rdata` in DATA_W: from RAM `rdata`; high-Z when RAM is not reading.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: a port is eligible when its `req`=1 and its `ack`=0 in that cycle, so a held request is not re-accepted in its ack cycle. The winning port's address, direction and write data are registered onto `ram_addr`, `ram_wdata`, and `ram_wr` (writes) or `ram_rd` (reads). The grant is recorded, and the FSM moves to ACCESS.
- Arbitration by default is fixed priority: data port over fetch. Fetch is always a read.
- ACCESS: the RAM samples its strobe this cycle, and `ram_wr`/`ram_rd` clear at the end of the cycle.
  - Write: assert the granted `ack` next cycle, then go to IDLE.
  - Read: go to RESP.
- RESP: capture `ram_rdata` into the granted port's `rdata`, assert its `ack` next cycle, then go to IDLE.
- `ram_rdata` is sampled only in RESP. `if_rdata`/`d_rdata` hold their last captured value otherwise and never show Z.
- Out-of-range addresses (bit 8 = 1, beyond the 256-entry RAM) use the same FSM path and latency. No `ram_wr`/`ram_rd` strobe is asserted, and a read returns 32'h0.
- The non-granted port's request simply waits. No request is lost or reordered within a port.
- `ram_addr` and `ram_wdata` hold their last values between accesses.

## Timing
- Reset values:
  - outputs: `if_ack`, `d_ack`, `ram_wr`, `ram_rd`, `busy` = 0; `if_rdata`, `d_rdata`, `ram_addr`, `ram_wdata` = 0.
  - internal state: FSM = IDLE; round-robin pointer = data.
- Request sampled at edge E0:
  - Strobes are high from E0 to E1, and the RAM acts at E1.
  - Write: `ack` is high from E1 to E2 (2 cycles).
  - Read: RAM data is valid from E1, captured at E2, and `ack`+`rdata` are high from E2 to E3 (3 cycles).
- Back-to-back: the earliest next acceptance is the edge that ends the ack cycle. Sustained throughput is one read per 3 cycles or one write per 2 cycles.
- Requester rule: `req`, `addr`, `we`, `wdata` stay stable from assertion through the ack cycle. Dropping `req` early is illegal once accepted; the access still completes and acks.
- Reset mid-access: the access is abandoned at the reset edge. Strobes drop, no ack is produced, and the RAM contents for a write in ACCESS are undefined.

## Configuration
- `MEM_CTRL_RR_EN` defined: round-robin arbitration. When both ports are eligible in IDLE, the port not granted last wins. The pointer updates on every grant.
- Undefined: fixed data-over-fetch priority, and the pointer logic is absent.
- Single-requester behaviour and all latencies are identical in both builds.

## Test plan
- After reset: write `d_addr`=9'h001, `d_wdata`=32'h10F00010 -> `ram_wr`=1 for exactly one cycle with `ram_addr`=9'h001; `d_ack` 2 cycles after acceptance.
- Read 9'h001 via fetch -> `if_ack` 3 cycles after acceptance with `if_rdata`=32'h10F00010; `if_rdata` unchanged afterwards while `ram_rdata`=Z.
- `if_req` and `d_req` (read 9'h000) asserted in the same cycle, both held:
  - default build: `d_ack` first, then `if_ack`.
  - with `MEM_CTRL_RR_EN` and last grant = data: `if_ack` first.
- Read of 9'h100 -> no `ram_rd` strobe; `d_ack` at 3 cycles with `d_rdata`=32'h0.
- `reset` asserted during ACCESS of a read -> `ram_rd`=0, `busy`=0 next cycle, no ack. A subsequent request completes normally.
- `d_req` held across its ack cycle, then dropped -> exactly one access and one `d_ack`.

Source files
------------

// File: rtl/mem_ctrl.sv
// Arbitrating access controller in front of the 256x32 single-port RAM.
// Optional build macro MEM_CTRL_RR_EN selects round-robin arbitration.
module mem_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_rd,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state;
  logic              gnt_d;
  logic              acc_we;
  logic              acc_oor;
  logic              if_elig;
  logic              d_elig;
  logic              pick_d;
  logic              sel_we;
  logic              sel_oor;
  logic [ADDR_W-1:0] sel_addr;
`ifdef MEM_CTRL_RR_EN
  logic              last_d;
`endif

  // A port in its ack cycle is not eligible, so a held request is not re-accepted.
  always_comb begin
    if_elig = if_req & ~if_ack;
    d_elig  = d_req & ~d_ack;
`ifdef MEM_CTRL_RR_EN
    pick_d  = d_elig & (~if_elig | ~last_d);
`else
    pick_d  = d_elig;
`endif
    sel_we   = pick_d & d_we;
    sel_addr = pick_d ? d_addr : if_addr;
    sel_oor  = sel_addr[ADDR_W-1];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_wr    <= 1'b0;
      ram_rd    <= 1'b0;
      gnt_d     <= 1'b0;
      acc_we    <= 1'b0;
      acc_oor   <= 1'b0;
`ifdef MEM_CTRL_RR_EN
      last_d    <= 1'b1;
`endif
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (if_elig | d_elig) begin
            gnt_d    <= pick_d;
            acc_we   <= sel_we;
            acc_oor  <= sel_oor;
            ram_addr <= sel_addr;
            if (sel_we)
              ram_wdata <= d_wdata;
            // Out-of-range accesses follow the normal path but never strobe the RAM.
            ram_wr   <= sel_we & ~sel_oor;
            ram_rd   <= ~sel_we & ~sel_oor;
            state    <= ACCESS;
            busy     <= 1'b1;
`ifdef MEM_CTRL_RR_EN
            last_d   <= pick_d;
`endif
          end
        end
        ACCESS: begin
          ram_wr <= 1'b0;
          ram_rd <= 1'b0;
          if (acc_we) begin
            d_ack <= 1'b1;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= RESP;
          end
        end
        RESP: begin
          if (gnt_d) begin
            d_rdata <= acc_oor ? '0 : ram_rdata;
            d_ack   <= 1'b1;
          end else begin
            if_rdata <= acc_oor ? '0 : ram_rdata;
            if_ack   <= 1'b1;
          end
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: behavioural RAM, reference memory model,
// directed corner cases followed by randomized single and contending requests.
module tb_mem_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req;
  logic [8:0]  if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [8:0]  d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic [8:0]  ram_addr;
  logic        ram_wr;
  logic [31:0] ram_wdata;
  logic        ram_rd;
  wire  [31:0] ram_rdata;
  logic        busy;

  mem_ctrl #(.ADDR_W(9), .DATA_W(32)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_wdata(ram_wdata), .ram_rd(ram_rd),
    .ram_rdata(ram_rdata), .busy(busy)
  );

  always #5 clock = ~clock;

  // Behavioural RAM: registered read, bus floats when not reading.
  logic [31:0] ram_mem [256];
  logic [31:0] ram_q;
  logic        ram_v;
  always @(posedge clock) begin
    if (ram_wr) ram_mem[ram_addr[7:0]] <= ram_wdata;
    ram_v <= ram_rd;
    if (ram_rd) ram_q <= ram_mem[ram_addr[7:0]];
  end
  assign ram_rdata = ram_v ? ram_q : 32'bz;

  typedef struct {
    bit          is_d;
    bit          rd;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem [256];
  bit          last_d;
  int          checks   = 0;
  int          failures = 0;
  int          wr_cnt   = 0;
  int          rd_cnt   = 0;
  int          ack_cnt  = 0;
  int          exp_wr   = 0;
  int          exp_rd   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: apply one granted access to the abstract memory.
  function automatic void model(input bit is_d, input bit we, input logic [8:0] a,
                                input logic [31:0] wd);
    exp_t e;
    e.is_d = is_d;
    e.rd   = !we;
    e.data = '0;
    if (!a[8]) begin
      if (we) begin
        ref_mem[a[7:0]] = wd;
        exp_wr++;
      end else begin
        e.data = ref_mem[a[7:0]];
        exp_rd++;
      end
    end
    last_d = is_d;
    sb.push_back(e);
  endfunction

  // Monitor: strobe accounting and scoreboard comparison on every ack.
  always @(posedge clock) begin
    #1;
    if (!reset) begin
      if (ram_wr) wr_cnt++;
      if (ram_rd) rd_cnt++;
      if (d_ack && if_ack) begin
        chk("dual_ack", 32'd1, 32'd0);
      end else if (d_ack || if_ack) begin
        ack_cnt++;
        if (sb.size() == 0) begin
          chk("spurious_ack", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("ack_port_is_d", {31'd0, d_ack}, {31'd0, e.is_d});
          if (e.rd) chk("rdata", d_ack ? d_rdata : if_rdata, e.data);
        end
      end
    end
  end

  // Issue a data and/or fetch request in the same cycle, hold each through its
  // ack cycle, and optionally check single-requester latency.
  task automatic issue(input bit en_d, input bit we, input logic [8:0] da,
                       input logic [31:0] wd, input bit en_i, input logic [8:0] ia,
                       input bit chk_lat);
    bit d_pend, i_pend, d_drop, i_drop, d_first;
    int cyc;
`ifdef MEM_CTRL_RR_EN
    d_first = !last_d;
`else
    d_first = 1'b1;
`endif
    if (en_d && en_i) begin
      if (d_first) begin
        model(1'b1, we, da, wd);
        model(1'b0, 1'b0, ia, '0);
      end else begin
        model(1'b0, 1'b0, ia, '0);
        model(1'b1, we, da, wd);
      end
    end else if (en_d) begin
      model(1'b1, we, da, wd);
    end else if (en_i) begin
      model(1'b0, 1'b0, ia, '0);
    end
    @(negedge clock);
    d_req = en_d; d_we = we; d_addr = da; d_wdata = wd;
    if_req = en_i; if_addr = ia;
    d_pend = en_d; i_pend = en_i; d_drop = 0; i_drop = 0; cyc = 0;
    while ((d_pend || i_pend || d_drop || i_drop) && cyc < 40) begin
      @(posedge clock);
      #1;
      cyc++;
      if (d_drop) begin d_req = 0; d_drop = 0; end
      if (i_drop) begin if_req = 0; i_drop = 0; end
      if (d_pend && d_ack) begin
        d_pend = 0; d_drop = 1;
        if (chk_lat) chk("d_latency", cyc, we ? 32'd2 : 32'd3);
      end
      if (i_pend && if_ack) begin
        i_pend = 0; i_drop = 1;
        if (chk_lat) chk("if_latency", cyc, 32'd3);
      end
    end
    if (d_pend || i_pend) begin
      chk("ack_timeout", 32'd1, 32'd0);
      d_req = 0; if_req = 0;
    end
  endtask

  initial begin
    int          r0, r1;
    logic [31:0] held;
    logic [31:0] rv;
    logic [8:0]  a1, a2;
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = '0;
      ref_mem[i] = '0;
    end
    last_d = 1'b1;
    reset = 1; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_acks_busy", {27'd0, if_ack, d_ack, ram_wr, ram_rd, busy}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_ram_addr", {23'd0, ram_addr}, 32'd0);
    chk("rst_ram_wdata", ram_wdata, 32'd0);
    @(negedge clock);
    reset = 0;

    // Directed: write then fetch read back, held rdata while bus floats.
    r0 = wr_cnt;
    issue(1, 1, 9'h001, 32'h10F00010, 0, 9'h000, 1);
    chk("first_write_one_strobe", wr_cnt - r0, 32'd1);
    chk("ram_addr_after_write", {23'd0, ram_addr}, 32'h001);
    issue(0, 0, 9'h000, '0, 1, 9'h001, 1);
    held = if_rdata;
    repeat (4) @(posedge clock);
    #1;
    chk("if_rdata_held", if_rdata, 32'h10F00010);
    chk("if_rdata_held_vs_ack", if_rdata, held);

    // Contention: data last granted, then both ports read 9'h000.
    issue(1, 1, 9'h000, 32'hA5A5_0000, 0, 9'h000, 1);
    issue(1, 0, 9'h000, '0, 1, 9'h000, 0);

    // Out-of-range read: no strobe, zero data, normal latency.
    r0 = rd_cnt;
    issue(1, 0, 9'h100, '0, 0, 9'h000, 1);
    chk("oor_no_rd_strobe", rd_cnt - r0, 32'd0);
    r0 = wr_cnt;
    issue(1, 1, 9'h1FF, 32'hDEAD_BEEF, 0, 9'h000, 1);
    chk("oor_no_wr_strobe", wr_cnt - r0, 32'd0);

    // Reset during ACCESS of a read abandons it without an ack.
    r1 = ack_cnt;
    @(negedge clock);
    d_req = 1; d_we = 0; d_addr = 9'h001;
    @(posedge clock);
    #1;
    chk("mid_rd_strobe", {31'd0, ram_rd}, 32'd1);
    exp_rd++;
    @(negedge clock);
    reset = 1; d_req = 0;
    @(posedge clock);
    #1;
    chk("mid_reset_rd_low", {31'd0, ram_rd}, 32'd0);
    chk("mid_reset_busy_low", {31'd0, busy}, 32'd0);
    @(negedge clock);
    reset = 0;
    last_d = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    chk("mid_reset_no_ack", ack_cnt - r1, 32'd0);
    issue(0, 0, 9'h000, '0, 1, 9'h001, 1);

    // Held across ack cycle: exactly one access and one ack.
    r0 = rd_cnt; r1 = ack_cnt;
    issue(1, 0, 9'h001, '0, 0, 9'h000, 1);
    repeat (3) @(posedge clock);
    #1;
    chk("held_one_access", rd_cnt - r0, 32'd1);
    chk("held_one_ack", ack_cnt - r1, 32'd1);

    // Randomized mix of single and contending requests.
    for (int n = 0; n < 200; n++) begin
      rv = $urandom;
      a1 = {rv[4] & rv[5], 4'd0, rv[3:0]};
      a2 = {rv[12] & rv[13], 4'd0, rv[11:8]};
      case ($urandom_range(0, 3))
        0:       issue(1, 1, a1, $urandom, 0, 9'h000, 1);
        1:       issue(1, 0, a1, '0, 0, 9'h000, 1);
        2:       issue(0, 0, 9'h000, '0, 1, a2, 1);
        default: issue(1, rv[20], a1, $urandom, 1, a2, 0);
      endcase
    end

    repeat (4) @(posedge clock);
    #1;
    chk("sb_drained", sb.size(), 32'd0);
    chk("total_wr_strobes", wr_cnt, exp_wr);
    chk("total_rd_strobes", rd_cnt, exp_rd);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
